cpu_clock_ctrl: RTL
===================

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_LIMIT, default 249999, setting the step-key stable-time threshold in inclk0 cycles minus one.
REQ-002 The block SHALL have port inclk0, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick_in, input, 1 bit: the divided slow clock from the clock divider, synchronous to inclk0.
REQ-005 The block SHALL have port run_sw, input, 1 bit: run switch, asynchronous; 1 = free-run request.
REQ-006 The block SHALL have port step_key, input, 1 bit: single-step push-button, asynchronous, active-low.
REQ-007 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of cycle_count.
REQ-008 The block SHALL have port pc_in, input, 32 bits: current processor PC.
REQ-009 The block SHALL have port bp_addr, input, 32 bits: breakpoint address.
REQ-010 The block SHALL have port cpu_en, output, 1 bit: one-inclk0-cycle processor clock-enable pulse.
REQ-011 The block SHALL have port state, output, 2 bits: current state (PAUSE=0, RUN=1, STEP=2, HALT=3).
REQ-012 The block SHALL have port cycle_count, output, 32 bits: number of cpu_en pulses issued.

Function
REQ-013 tick_rise SHALL be tick_in high with its registered previous value low; one pulse per tick_in rising edge.
REQ-014 run_sw and step_key SHALL each pass through a 2-flop synchronizer; run_sync therefore lags run_sw by 2 cycles.
REQ-015 The synchronized step_key SHALL be debounced: step_db takes the new level only after the synchronized level differs from step_db for DEBOUNCE_LIMIT+1 consecutive cycles; any bounce restarts the count.
REQ-016 A step press event SHALL be a 1-to-0 transition of step_db, one cycle long; release generates no event.
REQ-017 PAUSE: run_sync=1 -> RUN; else step press -> STEP; if both in the same cycle, RUN wins and the press is discarded.
REQ-018 RUN: run_sync=0 -> PAUSE with no cpu_en that cycle, even if tick_rise is present; otherwise tick_rise -> cpu_en=1 for that cycle.
REQ-019 STEP: the first tick_rise SHALL produce exactly one cpu_en and transition to PAUSE; step presses while in STEP are ignored; run_sync does not affect STEP.
REQ-020 HALT: cpu_en SHALL stay 0; run_sync=0 -> PAUSE; run_sync=1 keeps HALT.
REQ-021 cpu_en SHALL be registered and SHALL assert in the cycle after the qualifying tick_rise; it is never high for two consecutive cycles.
REQ-022 cycle_count SHALL increment by 1 in each cycle cpu_en is high and SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 cnt_clr SHALL set cycle_count to 0 on the next edge and SHALL take priority over a simultaneous increment.

Reset
REQ-024 reset SHALL asynchronously force: state=PAUSE, cpu_en=0, cycle_count=0, tick_in history=0, run sync flops=0, step sync flops=1, step_db=1, debounce counter=0.
REQ-025 reset asserted mid-STEP or mid-RUN SHALL drop any pending pulse; the first cpu_en after release requires a fresh tick_rise.

Configuration
REQ-026 With macro CPU_CLOCK_CTRL_BREAKPOINT_EN defined, in RUN a tick_rise while pc_in==bp_addr SHALL transition to HALT without issuing cpu_en.
REQ-027 Breakpoint compare SHALL be ignored in STEP, so a step leaves the breakpoint address.
REQ-028 Without CPU_CLOCK_CTRL_BREAKPOINT_EN, pc_in and bp_addr SHALL be unused, HALT is unreachable, and the compare logic SHALL not be synthesized.

Verification (DEBOUNCE_LIMIT=3, tick_in period 10 inclk0 cycles)
REQ-029 Stimulus: reset released, run_sw=1 for 100 cycles. Required: state=RUN 3 cycles after run_sw; cpu_en pulses 1 cycle after each tick_in rise; cycle_count=10 at 100 cycles.
REQ-030 Stimulus: in PAUSE, step_key low for 2 cycles then high. Required: no event and cycle_count unchanged. Stimulus: step_key low for 10 cycles. Required: STEP, then exactly one cpu_en, then PAUSE, cycle_count +1.
REQ-031 Stimulus: run_sw dropped in the same cycle tick_rise occurs in RUN. Required: no cpu_en and state=PAUSE.
REQ-032 Stimulus: with the macro defined, bp_addr=0x10, pc_in reaches 0x10 in RUN. Required: HALT and no cpu_en. Stimulus: run_sw=0, then step. Required: PAUSE, one cpu_en despite the match.
REQ-033 Stimulus: cycle_count forced to 0xFFFFFFFF, then one pulse. Required: cycle_count=0. Stimulus: cnt_clr with a simultaneous pulse. Required: cycle_count=0.
REQ-034 Stimulus: reset asserted mid-STEP. Required: cpu_en=0, state=PAUSE, cycle_count=0 immediately, with no waiting for a clock edge.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
// Processor clock-enable controller. Turns a divided tick into single-cycle
// cpu_en pulses according to a run switch, a debounced single-step key and,
// optionally, a PC breakpoint that parks the processor in HALT.
// Optional feature macro: CPU_CLOCK_CTRL_BREAKPOINT_EN (breakpoint compare and
// the RUN -> HALT transition; when undefined pc_in/bp_addr are ignored).
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_LIMIT = 249999
) (
  input  logic        inclk0,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        run_sw,
  input  logic        step_key,
  input  logic        cnt_clr,
  input  logic [31:0] pc_in,
  input  logic [31:0] bp_addr,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  // Debounce counter only needs to reach DEBOUNCE_LIMIT.
  localparam int CW = (DEBOUNCE_LIMIT < 1) ? 1 : $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_LIMIT);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        cur_state;
  logic          tick_prev;
  logic          tick_rise;
  logic          run_meta;
  logic          run_sync;
  logic          step_meta;
  logic          step_sync;
  logic          step_db;
  logic          step_db_prev;
  logic          step_press;
  logic [CW-1:0] db_cnt;
  logic          bp_hit;

  assign state      = cur_state;
  assign tick_rise  = tick_in & ~tick_prev;
  // Press is the falling edge of the debounced (active-low) key.
  assign step_press = step_db_prev & ~step_db;

`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
  assign bp_hit = (pc_in == bp_addr);
`else
  // No compare hardware; the PC inputs are deliberately left dangling.
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc_in, bp_addr};
  assign bp_hit = 1'b0;
`endif

  // Remember the previous tick level for rising-edge detection.
  always_ff @(posedge inclk0 or posedge reset) begin
    if (reset) begin
      tick_prev <= 1'b0;
    end else begin
      tick_prev <= tick_in;
    end
  end

  // Two-flop synchronizers for the asynchronous switch and key.
  always_ff @(posedge inclk0 or posedge reset) begin
    if (reset) begin
      run_meta  <= 1'b0;
      run_sync  <= 1'b0;
      step_meta <= 1'b1;
      step_sync <= 1'b1;
    end else begin
      run_meta  <= run_sw;
      run_sync  <= run_meta;
      step_meta <= step_key;
      step_sync <= step_meta;
    end
  end

  // Debounce: accept a new key level only after DEBOUNCE_LIMIT+1 stable cycles.
  always_ff @(posedge inclk0 or posedge reset) begin
    if (reset) begin
      step_db      <= 1'b1;
      step_db_prev <= 1'b1;
      db_cnt       <= '0;
    end else begin
      step_db_prev <= step_db;
      if (step_sync != step_db) begin
        if (db_cnt == DB_MAX) begin
          step_db <= step_sync;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Control FSM with a registered cpu_en pulse issued the cycle after tick_rise.
  always_ff @(posedge inclk0 or posedge reset) begin
    if (reset) begin
      cur_state <= PAUSE;
      cpu_en    <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      case (cur_state)
        PAUSE: begin
          if (run_sync) begin
            cur_state <= RUN;
          end else if (step_press) begin
            cur_state <= STEP;
          end
        end
        RUN: begin
          if (!run_sync) begin
            cur_state <= PAUSE;
          end else if (tick_rise) begin
            if (bp_hit) begin
              cur_state <= HALT;
            end else begin
              cpu_en <= 1'b1;
            end
          end
        end
        STEP: begin
          // Breakpoint is ignored here so a step can move off the match.
          if (tick_rise) begin
            cpu_en    <= 1'b1;
            cur_state <= PAUSE;
          end
        end
        HALT: begin
          if (!run_sync) begin
            cur_state <= PAUSE;
          end
        end
      endcase
    end
  end

  // Count issued pulses; clear wins over a simultaneous increment.
  always_ff @(posedge inclk0 or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (cnt_clr) begin
      cycle_count <= 32'd0;
    end else if (cpu_en) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule
